alu_pipe: RTL and testbench

//  Parametrised, handshaked ALU; successor of the fixed 8-bit combinational ALU.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_pipe_if.sv | 38 +++
 rtl/alu_mul_seq.sv | 59 +++++
 rtl/alu_pipe.sv | 157 +++++++++++++++
 tb/tb_alu_pipe.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode and state types
// for the handshaked ALU pipeline.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SRL  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_EQL  = 4'd7,
    OP_SRA  = 4'd8,
    OP_SLT  = 4'd9,
    OP_SLTU = 4'd10,
    OP_MUL  = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1
  } alu_state_e;

  localparam logic [3:0] OP_LAST_LEGAL = 4'd11;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_LAST_LEGAL;
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand input and result output
// handshakes of the ALU pipeline.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [3:0]       op_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] result_o;
  logic             flag_z_o;
  logic             flag_n_o;
  logic             flag_c_o;
  logic             flag_v_o;
  logic             err_o;

  modport master (
    output in_valid_i, a_i, b_i, op_i,
    output out_ready_i,
    input  in_ready_o, out_valid_o,
    input  result_o, err_o,
    input  flag_z_o, flag_n_o,
    input  flag_c_o, flag_v_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, op_i,
    input  out_ready_i,
    output in_ready_o, out_valid_o,
    output result_o, err_o,
    output flag_z_o, flag_n_o,
    output flag_c_o, flag_v_o
  );

endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add multiplier, one partial
// product per cycle, freezes on its last step when stalled.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic               i_stall,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_add;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_done;

  assign w_add     = r_b_sh[0] ? r_a_sh : '0;
  assign w_acc_nxt = r_acc + w_add;
  assign w_done    = r_busy && (r_cnt == '0);

  // product includes the final step so it is ready on the done edge
  assign o_product = w_acc_nxt;
  assign o_done    = w_done;
  assign o_busy    = r_busy;

  // iterate one bit per cycle; hold everything on a stalled last step
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc  <= '0;
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_acc  <= '0;
      r_a_sh <= {{WIDTH{1'b0}}, i_a};
      r_b_sh <= i_b;
      r_cnt  <= CW'(WIDTH - 1);
      r_busy <= 1'b1;
    end else if (r_busy && !(w_done && i_stall)) begin
      r_acc  <= w_acc_nxt;
      r_a_sh <= r_a_sh << 1;
      r_b_sh <= r_b_sh >> 1;
      if (w_done) r_busy <= 1'b0;
      else        r_cnt  <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with a registered result
// stage and a sequential shift-add multiply.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      reset,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  alu_state_e         r_state;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_z;
  logic               r_n;
  logic               r_c;
  logic               r_v;
  logic               r_err;

  logic               w_out_free;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_is_mul;
  logic               w_mul_start;
  logic               w_stall;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;
  logic [SHW-1:0]     w_sh;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_dif;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic               w_err;
  logic               w_ld_one;
  logic               w_ld_mul;
  logic               w_ld;
  logic [WIDTH-1:0]   w_ld_res;
  logic               w_ld_c;
  logic               w_ld_v;
  logic               w_ld_err;
  logic               w_sa;
  logic               w_sb;

  assign w_out_free  = !r_out_valid || bus.out_ready_i;
  assign w_in_ready  = !reset && (r_state == IDLE) && w_out_free;
  assign w_accept    = bus.in_valid_i && w_in_ready;
  assign w_is_mul    = (bus.op_i == OP_MUL);
  assign w_mul_start = w_accept && w_is_mul;
  assign w_stall     = !w_out_free;
  assign w_sh        = bus.b_i[SHW-1:0];
  assign w_sa        = bus.a_i[WIDTH-1];
  assign w_sb        = bus.b_i[WIDTH-1];
  assign w_sum       = {1'b0, bus.a_i} + {1'b0, bus.b_i};
  assign w_dif       = {1'b0, bus.a_i} - {1'b0, bus.b_i};

  // single-cycle datapath; MUL result comes from the sequencer
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    case (bus.op_i)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (w_sa == w_sb) && (w_sum[WIDTH-1] != w_sa);
      end
      OP_SUB: begin
        w_res = w_dif[WIDTH-1:0];
        w_c   = w_dif[WIDTH];
        w_v   = (w_sa != w_sb) && (w_dif[WIDTH-1] != w_sa);
      end
      OP_SLL:  w_res = bus.a_i << w_sh;
      OP_SRL:  w_res = bus.a_i >> w_sh;
      OP_AND:  w_res = bus.a_i & bus.b_i;
      OP_OR:   w_res = bus.a_i | bus.b_i;
      OP_XOR:  w_res = bus.a_i ^ bus.b_i;
      OP_EQL:  w_res = {{(WIDTH-1){1'b0}}, bus.a_i == bus.b_i};
      OP_SRA:  w_res = $signed(bus.a_i) >>> w_sh;
      OP_SLT:
        w_res = {{(WIDTH-1){1'b0}},
                 $signed(bus.a_i) < $signed(bus.b_i)};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, bus.a_i < bus.b_i};
      OP_MUL:  w_res = '0;
      default: w_err = !op_legal(bus.op_i);
    endcase
  end

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_mul_start),
    .i_stall   (w_stall),
    .i_a       (bus.a_i),
    .i_b       (bus.b_i),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_prod)
  );

  assign w_ld_one = w_accept && !w_is_mul;
  assign w_ld_mul = (r_state == MUL) && w_mul_busy
                 && w_mul_done && w_out_free;
  assign w_ld     = w_ld_one || w_ld_mul;
  assign w_ld_res = w_ld_mul ? w_prod[WIDTH-1:0] : w_res;
  assign w_ld_c   = w_ld_mul ? |w_prod[2*WIDTH-1:WIDTH] : w_c;
  assign w_ld_v   = w_ld_mul ? 1'b0 : w_v;
  assign w_ld_err = w_ld_mul ? 1'b0 : w_err;

  // control FSM plus output register with backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE:    if (w_mul_start) r_state <= MUL;
        MUL:     if (w_ld_mul)    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_ld) begin
        r_out_valid <= 1'b1;
        r_result    <= w_ld_res;
        r_z         <= ~|w_ld_res;
        r_n         <= w_ld_res[WIDTH-1];
        r_c         <= w_ld_c;
        r_v         <= w_ld_v;
        r_err       <= w_ld_err;
      end else if (bus.out_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = r_out_valid;
  assign bus.result_o    = r_result;
  assign bus.flag_z_o    = r_z;
  assign bus.flag_n_o    = r_n;
  assign bus.flag_c_o    = r_c;
  assign bus.flag_v_o    = r_v;
  assign bus.err_o       = r_err;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe at
// WIDTH=8 (directed) and WIDTH=16 (random stream).
module tb_alu_pipe;

  typedef struct packed {
    logic [15:0] res;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  bit   stream_done;
  exp_t q8[$];
  exp_t q16[$];

  alu_pipe_if #(.WIDTH(8))  b8 ();
  alu_pipe_if #(.WIDTH(16)) b16 ();

  alu_pipe #(.WIDTH(8)) u8 (
    .clk   (clk),
    .reset (rst),
    .bus   (b8)
  );

  alu_pipe #(.WIDTH(16)) u16 (
    .clk   (clk),
    .reset (rst),
    .bus   (b16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // reference: plain integer arithmetic on w-bit values
  function automatic exp_t model(input int w, input longint a,
                                 input longint b, input int op);
    longint m, hi, lo, sa, sb, r;
    int     sh;
    exp_t   e;
    m  = (longint'(1) << w) - 1;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    sa = ((a >> (w - 1)) & 1) != 0 ? a - (longint'(1) << w) : a;
    sb = ((b >> (w - 1)) & 1) != 0 ? b - (longint'(1) << w) : b;
    sh = int'(b % longint'(w));
    e  = '0;
    r  = 0;
    case (op)
      0: begin
        r   = a + b;
        e.c = (r > m);
        e.v = (sa + sb > hi) || (sa + sb < lo);
      end
      1: begin
        r   = a - b;
        e.c = (a < b);
        e.v = (sa - sb > hi) || (sa - sb < lo);
      end
      2:  r = a << sh;
      3:  r = a >> sh;
      4:  r = a & b;
      5:  r = a | b;
      6:  r = a ^ b;
      7:  r = (a == b) ? 1 : 0;
      8:  r = sa >>> sh;
      9:  r = (sa < sb) ? 1 : 0;
      10: r = (a < b) ? 1 : 0;
      11: begin
        r   = a * b;
        e.c = ((r >> w) != 0);
      end
      default: e.err = 1'b1;
    endcase
    r     = r & m;
    e.res = 16'(r);
    e.z   = (r == 0);
    e.n   = ((r >> (w - 1)) & 1) != 0;
    return e;
  endfunction

  // drive one op, push expectation when the handshake will fire
  task automatic issue(input bit wide, input longint a,
                       input longint b, input int op);
    int   t;
    bit   rdy;
    exp_t e;
    e = model(wide ? 16 : 8, a, b, op);
    if (wide) begin
      b16.in_valid_i = 1'b1;
      b16.a_i        = 16'(a);
      b16.b_i        = 16'(b);
      b16.op_i       = 4'(op);
    end else begin
      b8.in_valid_i = 1'b1;
      b8.a_i        = 8'(a);
      b8.b_i        = 8'(b);
      b8.op_i       = 4'(op);
    end
    t = 0;
    @(negedge clk);
    rdy = wide ? b16.in_ready_o : b8.in_ready_o;
    while (!rdy && t < 200) begin
      @(negedge clk);
      rdy = wide ? b16.in_ready_o : b8.in_ready_o;
      t++;
    end
    if (!rdy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got no accept want accept");
    end else if (wide) begin
      q16.push_back(e);
    end else begin
      q8.push_back(e);
    end
    @(posedge clk);
    #1;
    b8.in_valid_i  = 1'b0;
    b16.in_valid_i = 1'b0;
  endtask

  // cycles from accept until out_valid, in_ready must stay low
  task automatic wait_lat(input string nm, input int exp_n);
    int n;
    bit rdy_seen;
    n        = 0;
    rdy_seen = 1'b0;
    while (!b8.out_valid_o && n < 40) begin
      if (b8.in_ready_o) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_lat"}, 64'(n), 64'(exp_n));
    chk({nm, "_busy"}, 64'(rdy_seen), 64'(0));
  endtask

  task automatic chk_rst(input string nm);
    chk({nm, "_8"},
        64'({b8.in_ready_o, b8.out_valid_o, b8.result_o,
             b8.flag_z_o, b8.flag_n_o, b8.flag_c_o,
             b8.flag_v_o, b8.err_o}), 64'(0));
    chk({nm, "_16"},
        64'({b16.in_ready_o, b16.out_valid_o, b16.result_o,
             b16.flag_z_o, b16.flag_n_o, b16.flag_c_o,
             b16.flag_v_o, b16.err_o}), 64'(0));
  endtask

  // monitor: compare each consumed result against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst && b8.out_valid_o && b8.out_ready_i) begin
      if (q8.size() == 0) begin
        chk("dup8", 64'(1), 64'(0));
      end else begin
        e = q8.pop_front();
        chk("res8",
            64'({b8.result_o, b8.flag_z_o, b8.flag_n_o,
                 b8.flag_c_o, b8.flag_v_o, b8.err_o}),
            64'({e.res[7:0], e.z, e.n, e.c, e.v, e.err}));
      end
    end
    if (!rst && b16.out_valid_o && b16.out_ready_i) begin
      if (q16.size() == 0) begin
        chk("dup16", 64'(1), 64'(0));
      end else begin
        e = q16.pop_front();
        chk("res16",
            64'({b16.result_o, b16.flag_z_o, b16.flag_n_o,
                 b16.flag_c_o, b16.flag_v_o, b16.err_o}),
            64'(e));
      end
    end
  end

  initial begin
    int t;
    n_cmp = 0;
    n_bad = 0;
    stream_done = 1'b0;
    rst = 1'b1;
    b8.in_valid_i   = 1'b0;
    b8.a_i          = '0;
    b8.b_i          = '0;
    b8.op_i         = '0;
    b8.out_ready_i  = 1'b1;
    b16.in_valid_i  = 1'b0;
    b16.a_i         = '0;
    b16.b_i         = '0;
    b16.op_i        = '0;
    b16.out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_rst("reset");
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(b8.in_ready_o), 64'(1));

    // single-cycle ops back to back
    issue(0, 'hFF, 'h01, 0);
    chk("add_lat1", 64'(b8.out_valid_o), 64'(1));
    issue(0, 'h7F, 'h01, 0);
    issue(0, 'h03, 'h05, 1);
    issue(0, 'hFE, 'h01, 9);
    issue(0, 'hFE, 'h01, 10);
    issue(0, 'h80, 'h0B, 8);
    issue(0, 'h5A, 'h33, 13);
    issue(0, 'h5A, 'h5A, 7);
    repeat (3) @(posedge clk);
    #1;

    // multiply latency
    issue(0, 'h0F, 'h11, 11);
    wait_lat("mul_a", 8);
    repeat (2) @(posedge clk);
    #1;
    issue(0, 'h10, 'h10, 11);
    wait_lat("mul_b", 8);
    repeat (2) @(posedge clk);
    #1;

    // backpressure: result held, MUL waits for the drain
    b8.out_ready_i = 1'b0;
    issue(0, 1, 2, 0);
    chk("bp_valid", 64'(b8.out_valid_o), 64'(1));
    fork
      issue(0, 'h0D, 'h0B, 11);
      begin
        repeat (5) begin
          chk("bp_hold",
              64'({b8.in_ready_o, b8.result_o}), 64'(3));
          @(posedge clk);
          #1;
        end
        b8.out_ready_i = 1'b1;
      end
    join
    wait_lat("bp_mul", 8);
    repeat (3) @(posedge clk);
    #1;

    // reset in the middle of a multiply
    issue(0, 'h33, 'h07, 11);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    q8.delete();
    q16.delete();
    @(posedge clk);
    #1;
    chk_rst("mid_mul_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_fall_rdy",
        64'({b8.in_ready_o, b8.out_valid_o}), 64'(2));
    issue(0, 5, 6, 0);
    chk("fresh_add", 64'(b8.out_valid_o), 64'(1));
    repeat (3) @(posedge clk);
    #1;

    // random stream at WIDTH=16 with random backpressure
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          issue(1, longint'($urandom_range(0, 65535)),
                longint'($urandom_range(0, 65535)),
                int'($urandom_range(0, 15)));
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk);
          #1;
          b16.out_ready_i = 1'($urandom_range(0, 1));
        end
        b16.out_ready_i = 1'b1;
      end
    join
    t = 0;
    while ((q16.size() != 0 || q8.size() != 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    chk("drain16", 64'(q16.size()), 64'(0));
    chk("drain8", 64'(q8.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
